// File: rtl/fetch_pkg.sv
// Shared widths, constants and the queue entry type for the instruction fetch queue.
package fetch_pkg;
    localparam int XLEN   = 64;
    localparam int INST_W = 32;
    localparam logic [XLEN-1:0]   PC_STEP = 64'd4;
    localparam logic [INST_W-1:0] NOP     = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc,inst} FIFO with push/pop/flush; simultaneous push+pop on full is legal.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1,
    localparam int ENT_W = $bits(fetch_entry_t)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [ENT_W-1:0] data_i,
    output logic [ENT_W-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited fetch, in-order responses, redirect flush/drop.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to out_* when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             accept, rsp_ok, rsp_keep, bypass, push, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     head_e, push_e;

    // Inflight includes responses still owed for dropped requests, so the credit stays safe.
    assign imem_req  = reset && !redirect_valid &&
                       (({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_req_ready;

    assign rsp_ok   = imem_rsp_valid && (inflight_q != '0);
    assign rsp_keep = rsp_ok && (drop_cnt_q == '0) && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass    = fifo_empty && rsp_keep && out_ready;
    assign out_valid = !fifo_empty || bypass;
    assign out_pc    = bypass ? rsp_pc_q : head_e.pc;
    assign out_inst  = bypass ? imem_rsp_data : head_e.inst;
`else
    assign bypass    = 1'b0;
    assign out_valid = !fifo_empty;
    assign out_pc    = head_e.pc;
    assign out_inst  = head_e.inst;
`endif

    assign push   = rsp_keep && !bypass && (!fifo_full || pop);
    assign pop    = !fifo_empty && out_ready && !redirect_valid;
    assign push_e = '{pc: rsp_pc_q, inst: imem_rsp_data};

    // Responses return in order and fetch is sequential between redirects, so the PC of the
    // next kept response is simply a running pointer.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(rsp_ok);
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            rsp_pc_d   = align_pc(redirect_pc);
            drop_cnt_d = inflight_d;
        end else begin
            if (accept)   fetch_pc_d = fetch_pc_q + PC_STEP;
            if (rsp_keep) rsp_pc_d   = rsp_pc_q + PC_STEP;
            if (rsp_ok && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  (push_e),
        .head_o  (head_e),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model plus queue-level reference, directed phases then random traffic.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
    );

    typedef struct { logic [63:0] addr; int due; bit stale; } req_t;
    typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;

    req_t        pend[$];   // accepted requests awaiting a memory response
    ent_t        mq[$];     // instructions the queue should be holding
    logic [63:0] m_fpc;
    int          cyc, lat, checks, errors;
    bit          rsp_rand;

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        return a[33:2] ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rdy, input bit ordy, input bit redir, input logic [63:0] rpc);
        bit   rv, keep, bp, e_req, e_val, pop;
        ent_t e_out;
        req_t r;
        e_out = '{pc: '0, inst: '0};
        r     = '{addr: '0, due: 0, stale: 1'b0};
        @(negedge clk);
        imem_req_ready = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rv = (pend.size() > 0) && (pend[0].due <= cyc) && (!rsp_rand || $urandom_range(0, 3) != 0);
        if (rv) r = pend[0];
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? imem_word(r.addr) : $urandom;
        #1;
        keep  = rv && !r.stale && !redir;
        e_req = !redir && (mq.size() + pend.size()) < DEPTH;
        bp    = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bp = keep && ordy && (mq.size() == 0);
`endif
        e_val = (mq.size() > 0) || bp;
        if (mq.size() > 0) e_out = mq[0];
        else if (bp)       e_out = '{pc: r.addr, inst: imem_word(r.addr)};

        chk("imem_req", {63'b0, imem_req}, {63'b0, e_req});
        if (e_req) chk("imem_addr", imem_addr, m_fpc);
        chk("out_valid", {63'b0, out_valid}, {63'b0, e_val});
        if (e_val) begin
            chk("out_pc", out_pc, e_out.pc);
            chk("out_inst", {32'b0, out_inst}, {32'b0, e_out.inst});
        end

        pop = e_val && ordy && !redir;
        if (rv) void'(pend.pop_front());
        if (redir) begin
            mq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            m_fpc = {rpc[63:2], 2'b00};
        end else begin
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (keep && !bp) mq.push_back('{pc: r.addr, inst: imem_word(r.addr)});
        end
        if (e_req && rdy) begin
            pend.push_back('{addr: m_fpc, due: cyc + lat, stale: 1'b0});
            m_fpc = m_fpc + 64'd4;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("rst_imem_req", {63'b0, imem_req}, 64'd0);
        chk("rst_imem_addr", imem_addr, 64'h0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_out_inst", {32'b0, out_inst}, 64'h0);
        pend.delete();
        mq.delete();
        m_fpc = 64'h0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("req_after_rst", {63'b0, imem_req}, 64'd1);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; lat = 1; rsp_rand = 1'b0; m_fpc = 64'h0;
        reset = 1'b0; imem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        #2;
        chk("por_imem_req", {63'b0, imem_req}, 64'd0);
        chk("por_out_valid", {63'b0, out_valid}, 64'd0);
        do_reset();

        // streaming with single-cycle memory
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);
        // consumer stall fills the queue, then drains
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
        // long latency, redirect with responses outstanding
        lat = 3;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 64'h100);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
        // misaligned target
        step(1'b1, 1'b1, 1'b1, 64'h203);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);
        // redirect coinciding with pop and response
        lat = 1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 64'h400);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);
        // address wrap
        step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);

        rsp_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) lat = $urandom_range(1, 4);
            if (i == 1500) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
